// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: FSM states, load marker, wait bound.
// Constants only: no latency, no backpressure.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [3:0] W_LOAD   = 4'b0000;
    localparam int         MAX_WAIT = 15;

    function automatic logic is_load(input logic [3:0] w);
        return w == W_LOAD;
    endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// 2**ADDR_W x 32 single-port array with byte-lane writes and a registered read port.
// Read data appears one cycle after an enabled load access; contents are never reset.
module dmem_sram
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (is_load(we_i)) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the MEM-stage mreq/mres handshake; one request in flight, WAIT_STATES+2 cycles to mres.
// No backpressure signalling beyond busy: mreq is only sampled in IDLE, so the requester holds it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mreq,
    input  logic [3:0]        w_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              mres,
    output logic              busy
);

    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT) begin : g_bad_wait
        $error("dmem_responder: WAIT_STATES must be within 0..15");
    end

    localparam int         WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_LOAD);
    localparam logic       HAS_WAIT  = (WAIT_STATES > 0);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [3:0]          req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [31:0]         req_data_q;
    logic                mres_q;
    logic                busy_q;
    logic [31:0]         load_data_q;
    logic [31:0]         load_data_d;
    logic [31:0]         rdata;
    logic                resp_load;

    // The array's registered read word is only valid during RESP, so a load response
    // bypasses it straight to the output and the holding register keeps it afterwards.
    assign resp_load   = mres_q && is_load(req_we_q);
    assign load_data_d = resp_load ? rdata : load_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_we_q    <= W_LOAD;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            mres_q      <= 1'b0;
            busy_q      <= 1'b0;
            load_data_q <= '0;
        end else begin
            mres_q      <= 1'b0;
            load_data_q <= load_data_d;
            case (state_q)
                ST_IDLE: begin
                    if (mreq) begin
                        req_we_q   <= w_mem;
                        req_addr_q <= addr_mem;
                        req_data_q <= store_data;
                        busy_q     <= 1'b1;
                        if (HAS_WAIT) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_INIT;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    mres_q  <= 1'b1;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    dmem_sram #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .en_i    (state_q == ST_ACCESS),
        .we_i    (req_we_q),
        .addr_i  (req_addr_q),
        .wdata_i (req_data_q),
        .rdata_o (rdata)
    );

    assign load_data = load_data_d;
    assign mres      = mres_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: three instances (1, 0 and 3 wait states) against a word-array model.
module tb_dmem_responder;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mreq  [NDUT];
    logic [3:0]  w_mem [NDUT];
    logic [7:0]  addr  [NDUT];
    logic [31:0] sdata [NDUT];
    logic [31:0] ldata [NDUT];
    logic        mres  [NDUT];
    logic        busy  [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    int          ws_of  [NDUT] = '{1, 0, 3};
    logic [31:0] mem_m  [NDUT][256];
    logic [31:0] last_m [NDUT];

    dmem_responder #(.ADDR_W(8), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(rst_n), .mreq(mreq[0]), .w_mem(w_mem[0]), .addr_mem(addr[0]),
        .store_data(sdata[0]), .load_data(ldata[0]), .mres(mres[0]), .busy(busy[0]));
    dmem_responder #(.ADDR_W(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst_n), .mreq(mreq[1]), .w_mem(w_mem[1]), .addr_mem(addr[1]),
        .store_data(sdata[1]), .load_data(ldata[1]), .mres(mres[1]), .busy(busy[1]));
    dmem_responder #(.ADDR_W(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst_n), .mreq(mreq[2]), .w_mem(w_mem[2]), .addr_mem(addr[2]),
        .store_data(sdata[2]), .load_data(ldata[2]), .mres(mres[2]), .busy(busy[2]));

    // One complete request on instance d; expected latency is WAIT_STATES+2 edges counting the sample edge.
    task automatic txn(input int d, input logic [3:0] we, input logic [7:0] a, input logic [31:0] wd,
                       input bit hold, input bit scramble, output int resp_cyc);
        logic [31:0] exp_ld;
        int lat;
        int exp_lat;
        exp_lat = ws_of[d] + 2;
        if (we == 4'h0) begin
            exp_ld    = mem_m[d][a];
            last_m[d] = exp_ld;
        end else begin
            exp_ld = last_m[d];
            for (int i = 0; i < 4; i++)
                if (we[i]) mem_m[d][a][8*i +: 8] = wd[8*i +: 8];
        end
        mreq[d]  = 1'b1;
        w_mem[d] = we;
        addr[d]  = a;
        sdata[d] = wd;
        @(posedge clk); #1;
        if (!hold) mreq[d] = 1'b0;
        if (scramble) begin
            addr[d]  = ~a;
            sdata[d] = $urandom;
            w_mem[d] = 4'($urandom);
        end
        lat = 0;
        resp_cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            checks++;
            if (busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_flight d=%0d n=%0d got %b want 1", d, n, busy[d]);
            end
            if (mres[d] === 1'b1) begin
                lat = n;
                resp_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency d=%0d addr=%h got %0d want %0d", d, a, lat, exp_lat);
        end
        if (lat != 0) begin
            checks++;
            if (ldata[d] !== exp_ld) begin
                errors++;
                $display("FAIL load_data d=%0d we=%b addr=%h got %h want %h", d, we, a, ldata[d], exp_ld);
            end
            @(posedge clk); #1;
            checks++;
            if (mres[d] !== 1'b0 || busy[d] !== 1'b0) begin
                errors++;
                $display("FAIL resp_pulse_end d=%0d got mres=%b busy=%b want 0 0", d, mres[d], busy[d]);
            end
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (mres[d] !== 1'b0 || busy[d] !== 1'b0 || ldata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state d=%0d got mres=%b busy=%b ld=%h want 0 0 0",
                         d, mres[d], busy[d], ldata[d]);
            end
        end
    endtask

    task automatic test_full_store;
        int rc;
        txn(0, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, rc);
        txn(0, 4'h0, 8'h10, 32'h0, 1'b0, 1'b0, rc);
        checks++;
        if (ldata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL full_store_hold got %h want deadbeef", ldata[0]);
        end
    endtask

    task automatic test_lane_store;
        int rc;
        txn(0, 4'b0010, 8'h10, 32'h0000AA00, 1'b0, 1'b0, rc);
        txn(0, 4'h0, 8'h10, 32'h0, 1'b0, 1'b0, rc);
        checks++;
        if (ldata[0] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL lane_store got %h want deadaaef", ldata[0]);
        end
    endtask

    task automatic test_reset_midflight;
        int rc;
        mreq[0] = 1'b1; w_mem[0] = 4'h0; addr[0] = 8'h10; sdata[0] = 32'h0;
        @(posedge clk); #1;
        mreq[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy got %b want 1", busy[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) last_m[d] = 32'h0;
        checks++;
        if (mres[0] !== 1'b0 || busy[0] !== 1'b0 || ldata[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_async got mres=%b busy=%b ld=%h want 0 0 0", mres[0], busy[0], ldata[0]);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            checks++;
            if (mres[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_dropped n=%0d got mres=%b busy=%b want 0 0", n, mres[0], busy[0]);
            end
        end
        txn(0, 4'h0, 8'h10, 32'h0, 1'b0, 1'b0, rc);
        checks++;
        if (ldata[0] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL reset_storage_kept got %h want deadaaef", ldata[0]);
        end
    endtask

    task automatic test_latency;
        int rc;
        logic [7:0]  a;
        logic [31:0] v;
        for (int d = 1; d < NDUT; d++) begin
            for (int k = 0; k < 3; k++) begin
                a = 8'($urandom);
                v = $urandom;
                txn(d, 4'hF, a, v, 1'b0, 1'b0, rc);
                txn(d, 4'h0, a, 32'h0, 1'b0, 1'b0, rc);
            end
        end
    endtask

    task automatic test_back_to_back;
        int rc [3];
        logic [7:0] a [3];
        for (int k = 0; k < 3; k++) begin
            a[k] = 8'h40 + 8'(k);
            txn(0, 4'hF, a[k], $urandom, 1'b0, 1'b0, rc[k]);
        end
        for (int k = 0; k < 3; k++)
            txn(0, 4'h0, a[k], 32'h0, 1'b1, 1'b1, rc[k]);
        mreq[0] = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (rc[k] - rc[k-1] != 4) begin
                errors++;
                $display("FAIL b2b_period k=%0d got %0d want 4", k, rc[k] - rc[k-1]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra_request got busy=%b want 0", busy[0]);
        end
    endtask

    task automatic test_boundary;
        int rc;
        txn(0, 4'hF, 8'hFF, 32'h11111111, 1'b0, 1'b0, rc);
        txn(0, 4'hF, 8'h00, 32'h22222222, 1'b0, 1'b0, rc);
        txn(0, 4'h0, 8'hFF, 32'h0, 1'b0, 1'b0, rc);
        checks++;
        if (ldata[0] !== 32'h11111111) begin
            errors++;
            $display("FAIL boundary_ff got %h want 11111111", ldata[0]);
        end
        txn(0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, rc);
        checks++;
        if (ldata[0] !== 32'h22222222) begin
            errors++;
            $display("FAIL boundary_00 got %h want 22222222", ldata[0]);
        end
    endtask

    task automatic test_random;
        int rc;
        logic [3:0] we;
        for (int k = 0; k < 8; k++)
            txn(0, 4'hF, 8'h20 + 8'(k), $urandom, 1'b0, 1'b0, rc);
        for (int k = 0; k < 40; k++) begin
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            txn(0, we, 8'h20 + 8'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rc);
            mreq[0] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            mreq[d] = 1'b0; w_mem[d] = 4'h0; addr[d] = 8'h0; sdata[d] = 32'h0;
            last_m[d] = 32'h0;
        end
        #2 rst_n = 1'b0;
        #10;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_full_store;
        test_lane_store;
        test_reset_midflight;
        test_latency;
        test_back_to_back;
        test_boundary;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
